// File: rtl/dbus_mmio.sv
// rtl/dbus_mmio.sv - data-side bus endpoint: byte-lane RAM, timer with compare irq, buffered 8N1 UART TX
module dbus_mmio #(
  parameter int DMEM_WORDS   = 1024,
  parameter int CLKS_PER_BIT = 16,
  parameter int TXFIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwe,
  output logic [31:0] drdata,
  output logic        uart_tx,
  output logic        timer_irq
);

  localparam int AW = $clog2(DMEM_WORDS);
  localparam int FW = (TXFIFO_DEPTH > 1) ? $clog2(TXFIFO_DEPTH) : 1;
  localparam int CW = $clog2(CLKS_PER_BIT);

  localparam logic [31:0] RAM_BYTES     = 32'(DMEM_WORDS * 4);
  localparam logic [31:0] A_UART_DATA   = 32'h8000_0000;
  localparam logic [31:0] A_UART_STATUS = 32'h8000_0004;
  localparam logic [31:0] A_MTIME       = 32'h8000_0010;
  localparam logic [31:0] A_MTIMECMP    = 32'h8000_0014;
  localparam logic [31:0] A_TCTRL       = 32'h8000_0018;

  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [FW-1:0] PTR_LAST  = FW'(TXFIFO_DEPTH - 1);
  localparam logic [FW:0]   FIFO_FULL = (FW + 1)'(TXFIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // Byte-lane merge shared by RAM-like registers.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  we);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (we[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  function automatic logic [FW-1:0] ptr_inc(input logic [FW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Address decode; the low two address bits never take part in selection.
  logic [31:0]   word_addr;
  logic          ram_sel;
  logic          wr_any;
  logic          wr_ram;
  logic          wr_mtime;
  logic          wr_mtimecmp;
  logic          wr_tctrl;
  logic          push_req;
  logic [AW-1:0] ram_idx;
  logic          unused_addr_bits;

  assign word_addr        = {daddr[31:2], 2'b00};
  assign ram_sel          = (daddr < RAM_BYTES);
  assign ram_idx          = daddr[AW+1:2];
  assign wr_any           = |dwe;
  assign wr_ram           = wr_any && ram_sel;
  assign wr_mtime         = wr_any && (word_addr == A_MTIME);
  assign wr_mtimecmp      = wr_any && (word_addr == A_MTIMECMP);
  assign wr_tctrl         = wr_any && (word_addr == A_TCTRL);
  assign push_req         = dwe[0] && (word_addr == A_UART_DATA);
  assign unused_addr_bits = ^daddr[1:0];

  // Data RAM: no reset, lane-wise store, combinational read.
  logic [31:0] mem_q [DMEM_WORDS];

  // Commit the enabled byte lanes of a RAM store.
  always_ff @(posedge clk) begin
    if (wr_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (dwe[i]) mem_q[ram_idx][8*i +: 8] <= dwdata[8*i +: 8];
      end
    end
  end

  // Timer registers.
  logic [31:0] mtime_q, mtime_d;
  logic [31:0] mtimecmp_q, mtimecmp_d;
  logic        irq_en_q, irq_en_d;
  logic        timer_irq_q;

  // Next-state for timer: a bus write to MTIME replaces the increment.
  always_comb begin
    mtime_d    = wr_mtime ? lane_merge(mtime_q, dwdata, dwe) : mtime_q + 32'd1;
    mtimecmp_d = wr_mtimecmp ? lane_merge(mtimecmp_q, dwdata, dwe) : mtimecmp_q;
    irq_en_d   = (wr_tctrl && dwe[0]) ? dwdata[0] : irq_en_q;
  end

  // Timer state and registered interrupt from current register values.
  always_ff @(posedge clk) begin
    if (reset) begin
      mtime_q     <= 32'd0;
      mtimecmp_q  <= 32'hFFFF_FFFF;
      irq_en_q    <= 1'b0;
      timer_irq_q <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      irq_en_q    <= irq_en_d;
      timer_irq_q <= irq_en_q && (mtime_q >= mtimecmp_q);
    end
  end

  assign timer_irq = timer_irq_q;

  // UART TX FIFO.
  logic [7:0]    fifo_q [TXFIFO_DEPTH];
  logic [FW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FW:0]   count_q, count_d;
  logic          fifo_empty, fifo_full;
  logic          pop, push;
  logic [1:0]    state_q, state_d;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FIFO_FULL);
  assign pop        = (state_q == S_IDLE) && !fifo_empty;
  // A full FIFO still accepts a push when the slot is freed in the same cycle.
  assign push       = push_req && (!fifo_full || pop);

  // Occupancy changes only when exactly one of push/pop happens.
  always_comb begin
    count_d = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  // FIFO storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= dwdata[7:0];
  end

  // FIFO pointers and count.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_d;
    end
  end

  // TX serializer.
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;

  // Frame sequencing; tx_d is the line level for the coming cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (pop) begin
          state_d = S_START;
          cnt_d   = '0;
          shift_d = fifo_q[rd_ptr_q];
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_DATA;
          cnt_d   = '0;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Serializer registers; reset abandons any frame in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign uart_tx = tx_q;

  // Combinational read mux; unmapped addresses return zero.
  always_comb begin
    drdata = 32'd0;
    if (ram_sel) begin
      drdata = mem_q[ram_idx];
    end else begin
      case (word_addr)
        A_UART_STATUS: drdata = {29'd0, (state_q != S_IDLE), fifo_full, fifo_empty};
        A_MTIME:       drdata = mtime_q;
        A_MTIMECMP:    drdata = mtimecmp_q;
        A_TCTRL:       drdata = {31'd0, irq_en_q};
        default:       drdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_mmio.sv
// tb/tb_dbus_mmio.sv - directed self-checking bench for dbus_mmio
module tb_dbus_mmio;

  localparam int CPB = 4;

  localparam logic [31:0] A_UART_DATA   = 32'h8000_0000;
  localparam logic [31:0] A_UART_STATUS = 32'h8000_0004;
  localparam logic [31:0] A_MTIME       = 32'h8000_0010;
  localparam logic [31:0] A_MTIMECMP    = 32'h8000_0014;
  localparam logic [31:0] A_TCTRL       = 32'h8000_0018;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dwe;
  logic [31:0] drdata;
  logic        uart_tx;
  logic        timer_irq;

  int n_cmp = 0;
  int n_err = 0;

  dbus_mmio #(
    .DMEM_WORDS  (1024),
    .CLKS_PER_BIT(CPB),
    .TXFIFO_DEPTH(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .daddr    (daddr),
    .dwdata   (dwdata),
    .dwe      (dwe),
    .drdata   (drdata),
    .uart_tx  (uart_tx),
    .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    daddr  = a;
    dwdata = d;
    dwe    = we;
    tick();
    dwe    = 4'b0000;
  endtask

  task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    daddr = a;
    dwe   = 4'b0000;
    #1;
    chk(tag, drdata, exp);
  endtask

  // Receive one frame. off0 is the cycle offset into the frame (0 = first start-bit
  // cycle) at entry; when wait_start is set, poll for the start bit first.
  task automatic rx_frame(input string tag, input int off0, input bit wait_start,
                          input int exp_gap, input logic [7:0] exp);
    int         waited;
    int         off;
    logic [7:0] b;
    waited = 0;
    b      = 8'h00;
    if (wait_start) begin
      while (uart_tx !== 1'b0 && waited < 200) begin
        tick();
        waited++;
      end
      chk({tag, "_gap"}, 32'(waited), 32'(exp_gap));
    end
    off = off0;
    for (int k = 0; k < 8; k++) begin
      while (off < CPB * (k + 1) + CPB / 2) begin
        tick();
        off++;
      end
      b[k] = uart_tx;
    end
    while (off < 9 * CPB + CPB / 2) begin
      tick();
      off++;
    end
    chk({tag, "_stop"}, 32'(uart_tx), 32'd1);
    while (off < 10 * CPB) begin
      tick();
      off++;
    end
    chk({tag, "_data"}, 32'(b), 32'(exp));
  endtask

  initial begin
    logic [7:0] frame_byte;
    logic       exp_bit;
    int         w;

    reset  = 1'b1;
    daddr  = 32'd0;
    dwdata = 32'd0;
    dwe    = 4'b0000;
    tick();
    tick();

    // Reset state
    chk("rst_uart_tx", 32'(uart_tx), 32'd1);
    chk("rst_irq", 32'(timer_irq), 32'd0);
    chk_rd("rst_status", A_UART_STATUS, 32'h1);
    chk_rd("rst_mtime", A_MTIME, 32'h0);
    chk_rd("rst_mtimecmp", A_MTIMECMP, 32'hFFFF_FFFF);
    chk_rd("rst_tctrl", A_TCTRL, 32'h0);
    reset = 1'b0;
    tick();

    // RAM byte lanes
    wr(32'h40, 32'h1122_3344, 4'b1111);
    wr(32'h40, 32'hAA00_0000, 4'b1000);
    chk_rd("ram_lane", 32'h40, 32'hAA22_3344);
    chk_rd("ram_lane_a42", 32'h42, 32'hAA22_3344);
    daddr  = 32'h40;
    dwdata = 32'h0000_0055;
    dwe    = 4'b0001;
    #1;
    chk("ram_rw_old", drdata, 32'hAA22_3344);
    tick();
    dwe = 4'b0000;
    chk_rd("ram_rw_new", 32'h40, 32'hAA22_3355);

    // RAM boundary and aliasing beyond the top
    wr(32'h0, 32'hCAFE_F00D, 4'b1111);
    wr(32'hFFC, 32'h0BAD_BEEF, 4'b1111);
    chk_rd("ram_top", 32'hFFC, 32'h0BAD_BEEF);
    wr(32'h1000, 32'h1234_5678, 4'b1111);
    chk_rd("ram_past_top", 32'h1000, 32'h0);
    chk_rd("ram_no_alias", 32'h0, 32'hCAFE_F00D);

    // Unmapped address
    wr(32'h9000_0000, 32'hDEAD_BEEF, 4'b1111);
    chk_rd("unmapped_rd", 32'h9000_0000, 32'h0);
    chk_rd("unmapped_ram0", 32'h0, 32'hCAFE_F00D);
    chk_rd("unmapped_cmp", A_MTIMECMP, 32'hFFFF_FFFF);
    chk_rd("unmapped_tctrl", A_TCTRL, 32'h0);
    chk_rd("unmapped_status", A_UART_STATUS, 32'h1);

    // Timer compare interrupt
    wr(A_MTIMECMP, 32'd20, 4'b1111);
    wr(A_MTIME, 32'd0, 4'b1111);
    chk_rd("tmr_mtime0", A_MTIME, 32'd0);
    wr(A_TCTRL, 32'h1, 4'b1111);
    chk_rd("tmr_tctrl", A_TCTRL, 32'h1);
    repeat (19) tick();
    chk_rd("tmr_mtime20", A_MTIME, 32'd20);
    chk("tmr_irq_before", 32'(timer_irq), 32'd0);
    tick();
    chk_rd("tmr_mtime21", A_MTIME, 32'd21);
    chk("tmr_irq_rise", 32'(timer_irq), 32'd1);
    wr(A_MTIMECMP, 32'hFFFF_FFFF, 4'b1111);
    chk("tmr_irq_hold", 32'(timer_irq), 32'd1);
    tick();
    chk("tmr_irq_cmp_clr", 32'(timer_irq), 32'd0);
    wr(A_MTIMECMP, 32'd0, 4'b1111);
    chk("tmr_irq_lag", 32'(timer_irq), 32'd0);
    tick();
    chk("tmr_irq_cmp0", 32'(timer_irq), 32'd1);
    wr(A_TCTRL, 32'h0, 4'b1111);
    chk("tmr_irq_en_lag", 32'(timer_irq), 32'd1);
    tick();
    chk("tmr_irq_en_clr", 32'(timer_irq), 32'd0);
    wr(A_TCTRL, 32'hFFFF_FFFE, 4'b1111);
    chk_rd("tctrl_bit0_only", A_TCTRL, 32'h0);
    wr(A_MTIMECMP, 32'h1234_5678, 4'b1111);
    wr(A_MTIMECMP, 32'h0000_AB00, 4'b0010);
    chk_rd("cmp_lane", A_MTIMECMP, 32'h1234_AB78);
    wr(A_MTIME, 32'hFFFF_FFFF, 4'b1111);
    chk_rd("mtime_max", A_MTIME, 32'hFFFF_FFFF);
    tick();
    chk_rd("mtime_wrap", A_MTIME, 32'h0);

    // Single UART frame, 0xA5
    wr(A_UART_DATA, 32'h0000_00A5, 4'b0001);
    chk("uart_tx_after_push", 32'(uart_tx), 32'd1);
    chk_rd("uart_status_pushed", A_UART_STATUS, 32'h0);
    chk_rd("uart_data_reads0", A_UART_DATA, 32'h0);
    tick();
    chk_rd("uart_status_busy", A_UART_STATUS, 32'h5);
    frame_byte = 8'hA5;
    for (int j = 0; j < 10; j++) begin
      if (j == 0) exp_bit = 1'b0;
      else if (j == 9) exp_bit = 1'b1;
      else exp_bit = frame_byte[j-1];
      for (int c = 0; c < CPB; c++) begin
        chk($sformatf("uart_bit%0d_c%0d", j, c), 32'(uart_tx), 32'(exp_bit));
        tick();
      end
    end
    chk_rd("uart_status_done", A_UART_STATUS, 32'h1);
    chk("uart_tx_idle", 32'(uart_tx), 32'd1);

    // FIFO overflow: six back-to-back pushes
    for (int i = 0; i < 6; i++) wr(A_UART_DATA, 32'(i + 1), 4'b0001);
    chk_rd("fifo_full_status", A_UART_STATUS, 32'h6);
    rx_frame("frame0", 4, 1'b0, 0, 8'h01);
    for (int i = 1; i < 5; i++) rx_frame($sformatf("frame%0d", i), 0, 1'b1, 1, 8'(i + 1));
    w = 0;
    while (uart_tx === 1'b1 && w < 60) begin
      tick();
      w++;
    end
    chk("no_sixth_frame", 32'(w), 32'd60);
    chk_rd("fifo_drained", A_UART_STATUS, 32'h1);

    // Reset in the middle of the data bits
    wr(A_UART_DATA, 32'h0, 4'b0001);
    wr(A_UART_DATA, 32'h0, 4'b0001);
    repeat (6) tick();
    chk("mid_data_tx", 32'(uart_tx), 32'd0);
    chk_rd("mid_data_status", A_UART_STATUS, 32'h4);
    reset = 1'b1;
    tick();
    chk("rst_mid_tx", 32'(uart_tx), 32'd1);
    chk_rd("rst_mid_status", A_UART_STATUS, 32'h1);
    chk_rd("rst_mid_mtime", A_MTIME, 32'h0);
    reset = 1'b0;
    tick();
    chk("post_rst_tx", 32'(uart_tx), 32'd1);
    chk_rd("post_rst_status", A_UART_STATUS, 32'h1);
    chk_rd("post_rst_ram_kept", 32'h40, 32'hAA22_3355);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dbus_mmio.md
# dbus_mmio

Data-side bus endpoint for the single-cycle RV32I core: consumes the core's `daddr`/`dwdata`/`dwe` outputs and produces its `drdata` input. It decodes each access to one of three targets: byte-writable data RAM, a free-running 32-bit timer with compare interrupt, or a buffered 8N1 UART transmitter. Reads are combinational, so the core completes a load in one cycle. Writes commit on the rising clock edge.

## Interface
- `DMEM_WORDS`, 1024: data RAM depth in 32-bit words; power of two.
- `CLKS_PER_BIT`, 16: UART bit period in clk cycles; ≥2.
- `TXFIFO_DEPTH`, 4: UART TX FIFO entries; power of two.

- `clk` input 1: clock, all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `daddr` input 32: byte address from core ALU.
- `dwdata` input 32: store data, lanes already positioned by core.
- `dwe` input 4: byte-lane write enables; 0000 = no write.
- `drdata` output 32: read data, combinational from `daddr`.
- `uart_tx` output 1: serial line, registered, idle high.
- `timer_irq` output 1: registered level interrupt.

## Operation
- Address map; `daddr[1:0]` ignored everywhere:
  - RAM: `daddr < DMEM_WORDS*4`; word index `daddr[log2(DMEM_WORDS)+1:2]`.
  - 0x8000_0000 UART_DATA: write with `dwe[0]` pushes `dwdata[7:0]`; reads 0.
  - 0x8000_0004 UART_STATUS, read-only: {29'b0, busy, full, empty}.
  - 0x8000_0010 MTIME, R/W.
  - 0x8000_0014 MTIMECMP, R/W.
  - 0x8000_0018 TCTRL, R/W: bit0 irq_en; other bits read 0.
  - Other addresses read 0x0000_0000; writes ignored.
- RAM writes: `dwe[i]` writes `dwdata[8i+7:8i]` to byte i of the addressed word. No shifting in this block.
- MTIME, MTIMECMP and TCTRL honour byte lanes identically to RAM.
- Timer:
  - `mtime` increments every cycle and wraps 0xFFFF_FFFF→0.
  - A write to MTIME overrides that cycle's increment. The written value is visible the next cycle, then increments.
  - `timer_irq <= irq_en && (mtime >= mtimecmp)`, unsigned compare on current register values.
- UART FIFO:
  - A push into a full FIFO is dropped, except when the TX FSM pops in the same cycle; then the push is accepted and the count is unchanged.
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE: `uart_tx`=1. When FIFO non-empty, pop into shift register → START.
  - START: `uart_tx`=0 for CLKS_PER_BIT cycles → DATA.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each → STOP.
  - STOP: `uart_tx`=1 for CLKS_PER_BIT cycles → IDLE.
  - `busy` = state≠IDLE.

## Timing
- Reset values: `uart_tx`=1, FSM=IDLE, FIFO empty, `mtime`=0, `mtimecmp`=0xFFFF_FFFF, `irq_en`=0, `timer_irq`=0. RAM contents are not reset.
- `drdata` has zero-cycle latency.
- A read and a write to the same location in one cycle returns the old value.
- UART latency:
  - Push at edge N: `empty`=0 after N.
  - FSM pops at edge N+1.
  - `uart_tx` falls after N+1.
- Frame is exactly 10·CLKS_PER_BIT cycles. Back-to-back bytes insert one IDLE cycle between frames.
- `timer_irq` lags the compare condition by one cycle. It clears one cycle after `irq_en`=0 or after MTIMECMP is raised above `mtime`.
- Reset mid-frame: `uart_tx`=1 after the reset edge, FIFO contents discarded, partial frame abandoned.

## Test plan
- RAM lanes: write 0x11223344 with `dwe`=1111 to 0x40, then 0xAA000000 with `dwe`=1000 → read of 0x40 returns 0xAA223344; read of 0x42 returns the same word.
- UART frame (CLKS_PER_BIT=4): push 0xA5 → `uart_tx` low 2 edges after the push, then bits 1,0,1,0,0,1,0,1 of 4 cycles each, then stop high; STATUS reads 0x1 after completion.
- FIFO overflow: push 6 bytes back-to-back while idle → first byte popped at once, 4 buffered, 6th dropped; exactly 5 frames emitted.
- Timer: write MTIMECMP=20, TCTRL=1, MTIME=0 → `timer_irq` rises at the cycle `mtime`=21 is visible; writing MTIMECMP=0xFFFF_FFFF → `timer_irq` low the next cycle. MTIME=0xFFFF_FFFF → next read returns 0.
- Unmapped/reset: write to 0x9000_0000 → all state unchanged, read returns 0. Assert reset mid-DATA → `uart_tx`=1 and STATUS=0x1 after the reset edge.
